// File: rtl/store_narrow_unit.sv
// Store narrowing + DEPTH-entry store buffer; legal stores reach mem_* one cycle after acceptance, req_ready drops when full.
// Optional tail write-combining under STORE_WR_COMBINE_EN (merges may be accepted while full).
module store_narrow_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [AW-1:0]            req_addr,
  input  logic [31:0]              req_data,
  input  logic [1:0]               req_size,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [AW-1:0]            mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  output logic                     misalign,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    be_q   [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          mis_q;

  logic [1:0]    off;
  logic [31:0]   pk_data;
  logic [3:0]    pk_be;
  logic          legal;
  logic [AW-1:0] word_addr;
  logic          full;
  logic          accept;
  logic          push;
  logic          pop;

  assign off       = req_addr[1:0];
  assign word_addr = {req_addr[AW-1:2], 2'b00};

  always_comb begin
    pk_data = 32'h0;
    pk_be   = 4'b0000;
    legal   = 1'b0;
    case (req_size)
      2'b00: begin
        pk_data = {4{req_data[7:0]}};
        pk_be   = 4'b0001 << off;
        legal   = 1'b1;
      end
      2'b01: begin
        pk_data = {2{req_data[15:0]}};
        pk_be   = off[1] ? 4'b1100 : 4'b0011;
        legal   = ~off[0];
      end
      2'b10: begin
        pk_data = req_data;
        pk_be   = 4'b1111;
        legal   = (off == 2'b00);
      end
      default: begin
        pk_data = 32'h0;
        pk_be   = 4'b0000;
        legal   = 1'b0;
      end
    endcase
  end

  assign full = (cnt == CW'(DEPTH));

`ifdef STORE_WR_COMBINE_EN
  logic [PW-1:0] tail;
  logic          merge_hit;
  logic          do_merge;

  // Merging needs a tail distinct from the head so the presented entry never changes under memory.
  assign tail      = wr_ptr - 1'b1;
  assign merge_hit = legal & (cnt >= CW'(2)) & (addr_q[tail] == word_addr);
  assign req_ready = ~full | merge_hit;
  assign do_merge  = accept & merge_hit;
  assign push      = accept & legal & ~merge_hit;
`else
  assign req_ready = ~full;
  assign push      = accept & legal;
`endif

  assign accept    = req_valid & req_ready;
  assign mem_valid = (cnt != '0);
  assign pop       = mem_valid & mem_ready;

  assign mem_addr  = mem_valid ? addr_q[rd_ptr] : '0;
  assign mem_wdata = mem_valid ? data_q[rd_ptr] : 32'h0;
  assign mem_be    = mem_valid ? be_q[rd_ptr]   : 4'b0000;
  assign misalign  = mis_q;
  assign count     = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= 32'h0;
        be_q[i]   <= 4'b0000;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      mis_q  <= 1'b0;
    end else begin
      if (push) begin
        addr_q[wr_ptr] <= word_addr;
        data_q[wr_ptr] <= pk_data;
        be_q[wr_ptr]   <= pk_be;
        wr_ptr         <= wr_ptr + 1'b1;
      end
`ifdef STORE_WR_COMBINE_EN
      if (do_merge) begin
        for (int l = 0; l < 4; l++) begin
          if (pk_be[l]) data_q[tail][8*l +: 8] <= pk_data[8*l +: 8];
        end
        be_q[tail] <= be_q[tail] | pk_be;
      end
`endif
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      mis_q <= accept & ~legal;
    end
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Randomized + directed bench for store_narrow_unit against a queue-based store-buffer model.
module tb_store_narrow_unit;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        misalign;
  logic [2:0]  count;

  store_narrow_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_size(req_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .misalign(misalign), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic exp_mis = 1'b0;
  logic did_pop = 1'b0;
  logic last_acc = 1'b0;
  ent_t pop_act, pop_exp;

  // Lane i carries data byte (i mod size) and is enabled when it falls in [o, o+size).
  function automatic void pack(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                               output logic ok, output ent_t e);
    int nb;
    int o;
    nb   = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    o    = int'(a[1:0]);
    ok   = (s != 2'd3) && ((o % nb) == 0);
    e.a  = a - 32'(o);
    e.d  = 32'h0;
    e.be = 4'b0;
    for (int i = 0; i < 4; i++) begin
      e.d[8*i +: 8] = d[8*(i % nb) +: 8];
      if (i >= o && i < o + nb) e.be[i] = 1'b1;
    end
  endfunction

  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic mr);
    logic ok, acc, pop, merge;
    ent_t e, t;
    @(negedge clk);
    req_valid = v; req_addr = a; req_data = d; req_size = s; mem_ready = mr;
    #1;
    acc = v & req_ready;
    pop = mem_valid & mr;
    did_pop = pop;
    pop_act = '{a: mem_addr, d: mem_wdata, be: mem_be};
    pop_exp = (q.size() != 0) ? q[0] : '0;
    pack(a, d, s, ok, e);
    merge = 1'b0;
`ifdef STORE_WR_COMBINE_EN
    merge = ok && (q.size() >= 2) && (q[q.size()-1].a == e.a);
`endif
    @(posedge clk);
    if (acc && merge) begin
      t = q[q.size()-1];
      for (int i = 0; i < 4; i++) if (e.be[i]) t.d[8*i +: 8] = e.d[8*i +: 8];
      t.be = t.be | e.be;
      q[q.size()-1] = t;
    end
    if (pop && q.size() != 0) void'(q.pop_front());
    if (acc && ok && !merge) q.push_back(e);
    exp_mis  = acc & ~ok;
    last_acc = acc;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if ({mem_valid, misalign, count} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl got v=%b m=%b c=%0d want 0", mem_valid, misalign, count); end
    n_chk++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin n_fail++; $display("FAIL reset_data got %h %h %b want 0", mem_addr, mem_wdata, mem_be); end
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_byte();
    step(1'b1, 32'h13, 32'hAABBCCDD, 2'd0, 1'b0);
    n_chk++; if ({mem_valid, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h10, 32'hDDDDDDDD, 4'b1000}) begin
      n_fail++; $display("FAIL sb_pack got v=%b %h %h %b want 1 00000010 dddddddd 1000", mem_valid, mem_addr, mem_wdata, mem_be); end
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    n_chk++; if (!did_pop || count !== 3'd0) begin n_fail++; $display("FAIL sb_drain got pop=%b count=%0d want 1 0", did_pop, count); end
  endtask

  task automatic test_order();
    step(1'b1, 32'h22, 32'h00001234, 2'd1, 1'b0);
    step(1'b1, 32'h24, 32'hCAFEF00D, 2'd2, 1'b1);
    n_chk++; if (!did_pop || pop_act !== {32'h20, 32'h12341234, 4'b1100}) begin
      n_fail++; $display("FAIL order_first got %h want 00000020 12341234 1100", pop_act); end
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    n_chk++; if (!did_pop || pop_act !== {32'h24, 32'hCAFEF00D, 4'b1111}) begin
      n_fail++; $display("FAIL order_second got %h want 00000024 cafef00d 1111", pop_act); end
    n_chk++; if (count !== 3'd0 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL order_empty got c=%0d v=%b want 0 0", count, mem_valid); end
  endtask

  task automatic test_misalign();
    step(1'b1, 32'h31, 32'h11223344, 2'd2, 1'b1);
    n_chk++; if ({misalign, mem_valid, count} !== 5'b10000) begin n_fail++; $display("FAIL mis_word got m=%b v=%b c=%0d want 1 0 0", misalign, mem_valid, count); end
    step(1'b1, 32'h30, 32'h11223344, 2'd3, 1'b1);
    n_chk++; if ({misalign, mem_valid, count} !== 5'b10000) begin n_fail++; $display("FAIL mis_rsvd got m=%b v=%b c=%0d want 1 0 0", misalign, mem_valid, count); end
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    n_chk++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL mis_pulse got %b want 0", misalign); end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(1'b1, 32'h100 + 32'(i * 4), 32'hA000 + 32'(i), 2'd2, 1'b0);
      if (i == DEPTH - 1) begin
        n_chk++; if (count !== 3'(DEPTH) || req_ready !== 1'b0) begin n_fail++; $display("FAIL full_flag got c=%0d r=%b want %0d 0", count, req_ready, DEPTH); end
      end
    end
    n_chk++; if (last_acc !== 1'b0 || count !== 3'(DEPTH)) begin n_fail++; $display("FAIL full_reject got acc=%b c=%0d want 0 %0d", last_acc, count, DEPTH); end
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    n_chk++; if (count !== 3'(DEPTH - 1) || req_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop got c=%0d r=%b want %0d 1", count, req_ready, DEPTH - 1); end
    for (int i = 1; i < DEPTH; i++) begin
      step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
      n_chk++; if (!did_pop || pop_act !== {32'h100 + 32'(i * 4), 32'hA000 + 32'(i), 4'b1111}) begin
        n_fail++; $display("FAIL full_drain%0d got %h want %h", i, pop_act, {32'h100 + 32'(i * 4), 32'hA000 + 32'(i), 4'b1111}); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h200 + 32'(i * 8), 32'h5A5A0000 + 32'(i), 2'd2, 1'b0);
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({mem_valid, misalign, count, mem_addr, mem_wdata, mem_be} !== 73'h0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_out got v=%b c=%0d a=%h d=%h be=%b r=%b want zeros r=1", mem_valid, count, mem_addr, mem_wdata, mem_be, req_ready); end
    q.delete(); exp_mis = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
      n_chk++; if (mem_valid !== 1'b0 || did_pop) begin n_fail++; $display("FAIL midrst_idle%0d got v=%b pop=%b want 0 0", i, mem_valid, did_pop); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 3) != 0), 32'h300 + 32'($urandom_range(0, 11)), $urandom,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0));
      n_chk++; if (count !== 3'(q.size()) || mem_valid !== (q.size() != 0)) begin
        n_fail++; $display("FAIL rnd_count[%0d] got c=%0d v=%b want %0d", n, count, mem_valid, q.size()); end
      n_chk++; if (misalign !== exp_mis) begin n_fail++; $display("FAIL rnd_misalign[%0d] got %b want %b", n, misalign, exp_mis); end
      if (did_pop) begin
        n_chk++; if (pop_act !== pop_exp) begin n_fail++; $display("FAIL rnd_pop[%0d] got %h want %h", n, pop_act, pop_exp); end
      end
`ifndef STORE_WR_COMBINE_EN
      n_chk++; if (req_ready !== (q.size() != DEPTH)) begin n_fail++; $display("FAIL rnd_ready[%0d] got %b want %b", n, req_ready, q.size() != DEPTH); end
`endif
    end
    while (q.size() != 0 && n_chk < 100000) begin
      step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
      n_chk++; if (pop_act !== pop_exp) begin n_fail++; $display("FAIL rnd_drain got %h want %h", pop_act, pop_exp); end
    end
  endtask

`ifdef STORE_WR_COMBINE_EN
  task automatic test_combine();
    step(1'b1, 32'h40, 32'h0, 2'd2, 1'b0);
    step(1'b1, 32'h44, 32'h11, 2'd0, 1'b0);
    step(1'b1, 32'h45, 32'h22, 2'd0, 1'b0);
    n_chk++; if (count !== 3'd2) begin n_fail++; $display("FAIL comb_count got %0d want 2", count); end
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    n_chk++; if (mem_wdata[15:0] !== 16'h2211 || mem_be !== 4'b0011 || mem_addr !== 32'h44) begin
      n_fail++; $display("FAIL comb_tail got a=%h d=%h be=%b want 00000044 ....2211 0011", mem_addr, mem_wdata, mem_be); end
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_byte();
    test_order();
    test_misalign();
    test_full();
    test_reset_mid();
`ifdef STORE_WR_COMBINE_EN
    test_combine();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
